// File: rtl/bcd_contador_display.sv
// Prescaled up/down BCD counter with synchronous BCD load and 7-segment decode.
// Count, wrap and load_err are registered; HEX is decoded combinationally from count_bcd.
module bcd_contador_display #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lz_blank,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0]       presc;
  logic                step;
  logic                load_ok;
  logic                carry;
  logic [4*DIGITS-1:0] next_cnt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
  end

  // Ripple carry/borrow through the digits; carry out of the top digit means wrap.
  always_comb begin
    next_cnt = count_bcd;
    carry    = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (up) begin
          if (count_bcd[4*k +: 4] >= 4'd9) begin
            next_cnt[4*k +: 4] = 4'd0;
          end else begin
            next_cnt[4*k +: 4] = count_bcd[4*k +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_bcd[4*k +: 4] == 4'd0) begin
            next_cnt[4*k +: 4] = 4'd9;
          end else begin
            next_cnt[4*k +: 4] = count_bcd[4*k +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  assign step = en && !load && (presc == PMAX);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_bcd <= '0;
      presc     <= '0;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else if (load) begin
      presc    <= '0;
      wrap     <= 1'b0;
      load_err <= !load_ok;
      if (load_ok) count_bcd <= load_val;
    end else begin
      load_err <= 1'b0;
      wrap     <= step && carry;
      if (en) presc <= (presc == PMAX) ? '0 : presc + 1'b1;
      if (step) count_bcd <= next_cnt;
    end
  end

  // Scan from the top digit; blanking stops at the first nonzero digit or at digit 0.
  always_comb begin
    logic lead;
    lead = lz_blank;
    HEX  = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (k != 0 && lead && count_bcd[4*k +: 4] == 4'd0) begin
        HEX[7*k +: 7] = 7'b1111111;
      end else begin
        HEX[7*k +: 7] = seg7(count_bcd[4*k +: 4]);
        lead = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_contador_display.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_bcd_contador_display;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
  localparam logic [6:0] S9 = 7'b0000100, SB = 7'b1111111;

  typedef struct packed {
    logic [15:0] cnt;
    logic        w;
    logic        er;
    logic        hc;
    logic [27:0] hx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: PRESCALE=1
  logic        a_reset = 1'b0, a_en = 1'b0, a_up = 1'b0, a_load = 1'b0, a_lz = 1'b0;
  logic [15:0] a_lv = '0;
  logic [15:0] a_cnt;
  logic [27:0] a_hex;
  logic        a_wrap, a_err;

  // Instance B: PRESCALE=5
  logic        b_reset = 1'b0, b_en = 1'b0;
  logic [15:0] b_cnt;
  logic [27:0] b_hex;
  logic        b_wrap, b_err;

  bcd_contador_display #(.DIGITS(4), .PRESCALE(1)) dut_a (
    .CLOCK_50(clk), .reset(a_reset), .en(a_en), .up(a_up), .load(a_load),
    .load_val(a_lv), .lz_blank(a_lz), .count_bcd(a_cnt), .HEX(a_hex),
    .wrap(a_wrap), .load_err(a_err)
  );

  bcd_contador_display #(.DIGITS(4), .PRESCALE(5)) dut_b (
    .CLOCK_50(clk), .reset(b_reset), .en(b_en), .up(1'b1), .load(1'b0),
    .load_val(16'h0000), .lz_blank(1'b0), .count_bcd(b_cnt), .HEX(b_hex),
    .wrap(b_wrap), .load_err(b_err)
  );

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      chk("a_count", {16'h0, a_cnt}, {16'h0, ea.cnt});
      chk("a_wrap", {31'h0, a_wrap}, {31'h0, ea.w});
      chk("a_load_err", {31'h0, a_err}, {31'h0, ea.er});
      if (ea.hc) chk("a_hex", {4'h0, a_hex}, {4'h0, ea.hx});
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      chk("b_count", {16'h0, b_cnt}, {16'h0, eb.cnt});
      chk("b_wrap", {31'h0, b_wrap}, {31'h0, eb.w});
    end
  end

  task automatic cyc_a(input logic rst, input logic e, input logic u, input logic ld,
                       input logic [15:0] lv, input logic lz,
                       input logic [15:0] c, input logic w, input logic er,
                       input logic hc, input logic [27:0] hx);
    @(negedge clk);
    #1;
    a_reset = rst; a_en = e; a_up = u; a_load = ld; a_lv = lv; a_lz = lz;
    @(posedge clk);
    qa.push_back('{cnt: c, w: w, er: er, hc: hc, hx: hx});
  endtask

  task automatic cyc_b(input logic rst, input logic e, input logic [15:0] c);
    @(negedge clk);
    #1;
    b_reset = rst; b_en = e;
    @(posedge clk);
    qb.push_back('{cnt: c, w: 1'b0, er: 1'b0, hc: 1'b0, hx: 28'h0});
  endtask

  initial begin
    logic [15:0] bcd;
    // Reset state, both blanking modes
    cyc_a(1, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 0, 1, {S0, S0, S0, S0});
    cyc_a(1, 0, 0, 0, 16'h0, 1, 16'h0000, 0, 0, 1, {SB, SB, SB, S0});
    // Count up 12 steps
    for (int i = 1; i <= 12; i++) begin
      bcd = {8'h00, 4'(i / 10), 4'(i % 10)};
      cyc_a(0, 1, 1, 0, 16'h0, 0, bcd, 0, 0, (i == 12), {S0, S0, S1, S2});
    end
    // Up wrap
    cyc_a(0, 1, 1, 1, 16'h9998, 0, 16'h9998, 0, 0, 0, 28'h0);
    cyc_a(0, 1, 1, 0, 16'h0, 0, 16'h9999, 0, 0, 0, 28'h0);
    cyc_a(0, 1, 1, 0, 16'h0, 0, 16'h0000, 1, 0, 0, 28'h0);
    cyc_a(0, 1, 1, 0, 16'h0, 0, 16'h0001, 0, 0, 0, 28'h0);
    // Down wrap, then rejected load
    cyc_a(0, 0, 0, 1, 16'h0001, 0, 16'h0001, 0, 0, 0, 28'h0);
    cyc_a(0, 1, 0, 0, 16'h0, 0, 16'h0000, 0, 0, 0, 28'h0);
    cyc_a(0, 1, 0, 0, 16'h0, 0, 16'h9999, 1, 0, 1, {S9, S9, S9, S9});
    cyc_a(0, 1, 0, 1, 16'h12A4, 0, 16'h9999, 0, 1, 0, 28'h0);
    cyc_a(0, 0, 0, 0, 16'h0, 0, 16'h9999, 0, 0, 0, 28'h0);
    // Leading-zero blanking
    cyc_a(0, 0, 0, 1, 16'h0050, 1, 16'h0050, 0, 0, 1, {SB, SB, S5, S0});
    cyc_a(0, 0, 0, 1, 16'h0000, 1, 16'h0000, 0, 0, 1, {SB, SB, SB, S0});
    cyc_a(0, 0, 0, 1, 16'h1005, 1, 16'h1005, 0, 0, 1, {S1, S0, S0, S5});
    cyc_a(0, 0, 0, 1, 16'h0050, 0, 16'h0050, 0, 0, 1, {S0, S0, S5, S0});
    // Continuous rejected loads
    cyc_a(0, 1, 1, 1, 16'hF000, 0, 16'h0050, 0, 1, 0, 28'h0);
    cyc_a(0, 1, 1, 1, 16'h0F00, 0, 16'h0050, 0, 1, 0, 28'h0);
    cyc_a(0, 0, 1, 0, 16'h0, 0, 16'h0050, 0, 0, 0, 28'h0);
    // Reset overrides count at 9999 and a simultaneous load
    cyc_a(0, 0, 1, 1, 16'h9999, 0, 16'h9999, 0, 0, 0, 28'h0);
    cyc_a(1, 1, 1, 0, 16'h0, 0, 16'h0000, 0, 0, 0, 28'h0);
    cyc_a(0, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 0, 0, 28'h0);
    cyc_a(1, 1, 1, 1, 16'h4321, 0, 16'h0000, 0, 0, 0, 28'h0);
    cyc_a(0, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 0, 0, 28'h0);
    cyc_a(0, 0, 1, 1, 16'h4321, 0, 16'h4321, 0, 0, 1, {S4, S3, S2, S1});
    // Direction change between steps
    cyc_a(0, 1, 0, 0, 16'h0, 0, 16'h4320, 0, 0, 0, 28'h0);
    cyc_a(0, 1, 1, 0, 16'h0, 0, 16'h4321, 0, 0, 0, 28'h0);
    cyc_a(0, 0, 1, 0, 16'h0, 0, 16'h4321, 0, 0, 0, 28'h0);

    // Prescaler: 4 enabled, 3 disabled, 6 enabled -> steps on enabled cycles 5 and 10
    cyc_b(1, 0, 16'h0000);
    for (int i = 0; i < 4; i++) cyc_b(0, 1, 16'h0000);
    for (int i = 0; i < 3; i++) cyc_b(0, 0, 16'h0000);
    cyc_b(0, 1, 16'h0001);
    for (int i = 0; i < 4; i++) cyc_b(0, 1, 16'h0001);
    cyc_b(0, 1, 16'h0002);
    cyc_b(0, 0, 16'h0002);
    cyc_b(0, 0, 16'h0002);

    repeat (3) @(negedge clk);
    #1;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_contador_display.md
BCD_CONTADOR_DISPLAY -- requirements
Module: bcd_contador_display

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits and 7-segment displays; legal range 1..8.
REQ-002 Parameter PRESCALE, default 50000000: CLOCK_50 cycles per count step; a value of 1 steps on every enabled cycle.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  count enable; gates both the prescaler and the counter.
REQ-006 up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 load  input  1  synchronous load request for load_val.
REQ-008 load_val  input  4*DIGITS  BCD load value; digit k occupies bits [4k+3:4k].
REQ-009 lz_blank  input  1  when 1, enables leading-zero suppression on the display.
REQ-010 count_bcd  output  4*DIGITS  registered BCD count; digit k occupies bits [4k+3:4k].
REQ-011 HEX  output  7*DIGITS  active-low segments; digit k occupies bits [7k+6:7k], with segment a on bit 7k+6 through segment g on bit 7k.
REQ-012 wrap  output  1  registered one-cycle pulse on counter wrap-around.
REQ-013 load_err  output  1  registered one-cycle pulse when a load is rejected.

Function
REQ-014 Priority per cycle SHALL be: reset, then load, then count step.
REQ-015 Prescaler counts 0..PRESCALE-1 only while en=1, holds while en=0, and clears to 0 on reset or any load (accepted or rejected).
REQ-016 A step SHALL occur on a cycle with en=1, load=0 and the prescaler at PRESCALE-1; count_bcd updates on that edge, giving 1-cycle latency from the step cycle.
REQ-017 Up step: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit; digits never hold values above 9.
REQ-018 Down step: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
REQ-019 Up step from all-9s SHALL give all-0s, and down step from all-0s SHALL give all-9s; wrap is 1 in the cycle the wrapped value appears on count_bcd and 0 otherwise.
REQ-020 A change on up between steps takes effect at the next step; the prescaler phase is not disturbed.
REQ-021 Accepted load: if every digit of load_val is at most 9, count_bcd takes load_val on the next edge and wrap stays 0.
REQ-022 Rejected load: if any digit exceeds 9, count_bcd holds, load_err pulses 1 for one cycle, and no step occurs that cycle.
REQ-023 Continuous load=1 reloads (or re-rejects) every cycle; load_err stays 1 for every rejected cycle.
REQ-024 Segment encoding per digit (abcdefg, 0 = lit):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
REQ-025 HEX is decoded combinationally from count_bcd and lz_blank only, with no extra latency relative to count_bcd.
REQ-026 With lz_blank=1, every digit above the most-significant nonzero digit shows blank; digit 0 is never blanked, so a zero count shows a single "0".
REQ-027 With lz_blank=0, all digits are displayed.
REQ-028 Any unreachable digit code (greater than 9) SHALL decode to blank.

Reset
REQ-029 On an edge with reset=1:
  - count_bcd = 0, prescaler = 0, wrap = 0, load_err = 0;
  - HEX therefore = 0000001 on every digit with lz_blank=0, or on digit 0 only with the others 1111111 when lz_blank=1.
REQ-030 Reset asserted mid-count or during load SHALL override both, with no wrap or load_err pulse in that cycle or the next.

Verification (DIGITS=4, PRESCALE=1 unless stated)
REQ-031 Reset, then en=1 up=1 for 12 cycles -> count_bcd = 0x0012, and digit 1 shows 1001111 on HEX[13:7].
REQ-032 Load 0x9998, then en=1 up=1 -> 0x9999, then 0x0000 with wrap=1 for exactly one cycle, then 0x0001 with wrap=0.
REQ-033 Load 0x0001, then en=1 up=0 -> 0x0000, then 0x9999 with wrap=1; then load 0x12A4 -> count holds 0x9999 and load_err=1 for one cycle.
REQ-034 lz_blank=1 with count 0x0050 -> HEX digits 3..0 = 1111111, 1111111, 0100100, 0000001; at count 0x0000 -> three blanks then 0000001.
REQ-035 PRESCALE=5, en=1 for 10 cycles with en=0 for 3 cycles inserted after cycle 4 -> exactly 2 steps, with the second delayed by 3 cycles.
REQ-036 reset=1 in the same cycle as load=1 with load_val=0x4321 -> count_bcd = 0x0000 and load_err = 0.
